// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter and its decoder.
package regfile_pkg;
  localparam int WIDTH_DEF    = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_REG     = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Two-requester write bus plus the registered write-port outputs.
interface regfile_write_arbiter_if import regfile_pkg::*; #(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
);
  logic                hold;
  logic                req0_valid;
  logic [ADDR_W-1:0]   req0_addr;
  logic [WIDTH-1:0]    req0_data;
  logic                req0_ready;
  logic                req1_valid;
  logic [ADDR_W-1:0]   req1_addr;
  logic [WIDTH-1:0]    req1_data;
  logic                req1_ready;
  logic [NUM_REGS-1:0] wr_en;
  logic [WIDTH-1:0]    wr_data;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_src;

  modport master (
    output hold, req0_valid, req0_addr, req0_data,
           req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, wr_en, wr_data, wr_addr, wr_src
  );

  modport slave (
    input  hold, req0_valid, req0_addr, req0_data,
           req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, wr_en, wr_data, wr_addr, wr_src
  );
endinterface

// File: rtl/regfile_write_decoder.sv
// Address to one-hot write-enable decode; register 0 is never enabled.
module regfile_write_decoder import regfile_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [NUM_REGS-1:0] onehot_o
);
  assign onehot_o[ZERO_REG] = 1'b0;

  for (genvar k = 1; k < NUM_REGS; k++) begin : g_bit
    assign onehot_o[k] = (addr_i == ADDR_W'(k));
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two requesters.
module regfile_write_arbiter import regfile_pkg::*; #(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input logic                    clk,
  input logic                    reset_n,
  regfile_write_arbiter_if.slave bus
);
  req_idx_e            last_q, last_d, gnt_idx;
  req_idx_e            src_q, src_d;
  logic [NUM_REGS-1:0] en_q, en_d, dec;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, sel_addr;
  logic                gnt0, gnt1, xfer;

  // On contention the requester that did not win last time goes first.
  assign gnt0 = reset_n && !bus.hold && bus.req0_valid &&
                (!bus.req1_valid || last_q == REQ_MEM);
  assign gnt1 = reset_n && !bus.hold && bus.req1_valid &&
                (!bus.req0_valid || last_q == REQ_ALU);
  assign xfer     = gnt0 || gnt1;
  assign gnt_idx  = gnt1 ? REQ_MEM : REQ_ALU;
  assign sel_addr = gnt1 ? bus.req1_addr : bus.req0_addr;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  regfile_write_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_dec (
    .addr_i  (sel_addr),
    .onehot_o(dec)
  );

  always_comb begin
    last_d = last_q;
    en_d   = '0;
    data_d = data_q;
    addr_d = addr_q;
    src_d  = src_q;
    if (xfer) begin
      last_d = gnt_idx;
      en_d   = dec;
      data_d = gnt1 ? bus.req1_data : bus.req0_data;
      addr_d = sel_addr;
      src_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= REQ_MEM;
      en_q   <= '0;
      data_q <= '0;
      addr_q <= '0;
      src_q  <= REQ_ALU;
    end else begin
      last_q <= last_d;
      en_q   <= en_d;
      data_q <= data_d;
      addr_q <= addr_d;
      src_q  <= src_d;
    end
  end

  assign bus.wr_en   = en_q;
  assign bus.wr_data = data_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_src  = src_q;
endmodule
